// File: rtl/wb2axi_pkg.sv
// Shared types and helpers for the Wishbone-classic to AXI4-Lite bridge.
// Holds the FSM state encoding, AXI response codes and lane-steering helpers.
package wb2axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR_DATA,
    WRESP,
    RADDR,
    RDATA
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // The 32-bit Wishbone lane sits in the upper half of the 64-bit beat when adr[2] is set.
  function automatic logic [7:0] lane_strb(input logic lane, input logic [3:0] sel);
    return lane ? {sel, 4'h0} : {4'h0, sel};
  endfunction

  // EXOKAY (2'b01) counts as success; only the two error codes fail.
  function automatic logic resp_ok(input logic [1:0] resp);
    return (resp != RESP_SLVERR) && (resp != RESP_DECERR);
  endfunction

endpackage

// File: rtl/wb2axi.sv
// Wishbone classic 32-bit slave to 64-bit AXI4-Lite master bridge.
// One Wishbone cycle maps to exactly one AXI-Lite transaction, one outstanding at a time.
module wb2axi
  import wb2axi_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-3:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_wb_err,
  output logic [AW-1:0] o_awaddr,
  output logic          o_awvalid,
  input  logic          i_awready,
  output logic [63:0]   o_wdata,
  output logic [7:0]    o_wstrb,
  output logic          o_wvalid,
  input  logic          i_wready,
  input  logic [1:0]    i_bresp,
  input  logic          i_bvalid,
  output logic          o_bready,
  output logic [AW-1:0] o_araddr,
  output logic          o_arvalid,
  input  logic          i_arready,
  input  logic [63:0]   i_rdata,
  input  logic [1:0]    i_rresp,
  input  logic          i_rvalid,
  output logic          o_rready
);

  state_e        state_q, state_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          abort_q, abort_d;
  logic [31:0]   rdt_q, rdt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    wstrb_q, wstrb_d;
  logic          lane_q, lane_d;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    abort_d   = abort_q | ~i_wb_cyc;
    rdt_d     = rdt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    lane_d    = lane_q;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        // An err pulse terminates the cycle just like ack, so it also blocks re-acceptance.
        if (i_wb_cyc && i_wb_stb && !ack_q && !err_q) begin
          addr_d = {i_wb_adr[AW-3:1], 3'b000};
          lane_d = i_wb_adr[0];
          if (i_wb_we) begin
            wdata_d   = {i_wb_dat, i_wb_dat};
            wstrb_d   = lane_strb(i_wb_adr[0], i_wb_sel);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WADDR_DATA: begin
        if (awvalid_q && i_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (i_bvalid) begin
          bready_d = 1'b0;
          state_d  = IDLE;
          ack_d    = ~abort_d & resp_ok(i_bresp);
          err_d    = ~abort_d & ~resp_ok(i_bresp);
        end
      end
      RADDR: begin
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (i_rvalid) begin
          rready_d = 1'b0;
          state_d  = IDLE;
          if (!abort_d) rdt_d = lane_q ? i_rdata[63:32] : i_rdata[31:0];
          ack_d    = ~abort_d & resp_ok(i_rresp);
          err_d    = ~abort_d & ~resp_ok(i_rresp);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      rdt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
      rdt_q     <= rdt_d;
    end
  end

  // Address/data payload needs no reset: it is only observed while a valid is high.
  always_ff @(posedge i_clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
    lane_q  <= lane_d;
  end

  assign o_wb_rdt  = rdt_q;
  assign o_wb_ack  = ack_q;
  assign o_wb_err  = err_q;
  assign o_awaddr  = addr_q;
  assign o_araddr  = addr_q;
  assign o_awvalid = awvalid_q;
  assign o_wdata   = wdata_q;
  assign o_wstrb   = wstrb_q;
  assign o_wvalid  = wvalid_q;
  assign o_bready  = bready_q;
  assign o_arvalid = arvalid_q;
  assign o_rready  = rready_q;

endmodule

// File: tb/tb_wb2axi.sv
// Directed, table-driven bench for wb2axi with an in-bench AXI-Lite slave responder.
module tb_wb2axi;
  import wb2axi_pkg::*;

  localparam int AW = 12;

  logic          i_clk, i_rst;
  logic [AW-3:0] i_wb_adr;
  logic [31:0]   i_wb_dat;
  logic [3:0]    i_wb_sel;
  logic          i_wb_we, i_wb_cyc, i_wb_stb;
  logic [31:0]   o_wb_rdt;
  logic          o_wb_ack, o_wb_err;
  logic [AW-1:0] o_awaddr, o_araddr;
  logic          o_awvalid, i_awready;
  logic [63:0]   o_wdata;
  logic [7:0]    o_wstrb;
  logic          o_wvalid, i_wready;
  logic [1:0]    i_bresp;
  logic          i_bvalid, o_bready;
  logic          o_arvalid, i_arready;
  logic [63:0]   i_rdata;
  logic [1:0]    i_rresp;
  logic          i_rvalid, o_rready;

  wb2axi #(.AW(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
    .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        we;
    logic [9:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [1:0]  resp;
    logic [63:0] rdata;
    logic [11:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_wstrb;
    logic [31:0] e_rdt;
    logic        e_ack;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [31:0] rdt;
    int n_ack, n_err, ack_t, aw_hs, w_hs, ar_hs, r_hs, awv, wv;
    bit stable, rready_end, tmo;
  } res_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vt[9];
  res_t r;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [9:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic [1:0] resp, input logic [63:0] rdata,
                              input logic [11:0] e_addr, input logic [63:0] e_wdata,
                              input logic [7:0] e_wstrb, input logic [31:0] e_rdt,
                              input logic e_ack, input logic e_err);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.resp = resp; v.rdata = rdata;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_rdt = e_rdt;
    v.e_ack = e_ack; v.e_err = e_err;
    return v;
  endfunction

  task automatic idle_inputs();
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_arready = 0; i_rvalid = 0;
    i_bresp = 0; i_rresp = 0; i_rdata = 0;
  endtask

  // One Wishbone request; the slave answers each AXI valid after aw_dly / r_dly cycles.
  // stb stays high through the ack/err cycle, then drops.
  task automatic xfer(input vec_t v, input int aw_dly, input int r_dly, input bit abort,
                      output res_t res);
    int awc, rc, tail;
    bit done, fin;
    res.addr = 0; res.wdata = 0; res.wstrb = 0; res.rdt = 0;
    res.n_ack = 0; res.n_err = 0; res.ack_t = -1; res.aw_hs = 0; res.w_hs = 0;
    res.ar_hs = 0; res.r_hs = 0; res.awv = 0; res.wv = 0;
    res.stable = 1; res.rready_end = 0; res.tmo = 0;
    awc = 0; rc = 0; tail = 0; done = 0; fin = 0;
    @(negedge i_clk);
    i_wb_adr = v.adr; i_wb_dat = v.dat; i_wb_sel = v.sel; i_wb_we = v.we;
    i_wb_cyc = 1; i_wb_stb = 1;
    idle_inputs();
    for (int t = 0; t < 80; t++) begin
      if (t > 0) @(negedge i_clk);
      idle_inputs();
      if (o_awvalid) begin
        awc++; res.awv++;
        if (awc == 1) res.addr = o_awaddr;
        else if (o_awaddr != res.addr) res.stable = 0;
        if (awc >= aw_dly) begin i_awready = 1; res.aw_hs++; end
      end
      if (o_wvalid) begin
        res.wv++; i_wready = 1; res.w_hs++;
      end
      if (o_bready) begin i_bvalid = 1; i_bresp = v.resp; end
      if (o_arvalid) begin res.addr = o_araddr; i_arready = 1; res.ar_hs++; end
      if (o_rready) begin
        rc++;
        if (abort && rc == 1) begin i_wb_cyc = 0; i_wb_stb = 0; end
        if (rc >= r_dly) begin
          i_rvalid = 1; i_rdata = v.rdata; i_rresp = v.resp; res.r_hs++;
        end
      end
      if (done) begin
        i_wb_cyc = 0; i_wb_stb = 0; tail++;
      end
      if (o_wb_ack) begin res.n_ack++; res.ack_t = t; res.rdt = o_wb_rdt; end
      if (o_wb_err) begin res.n_err++; res.ack_t = t; end
      if (o_wb_ack || o_wb_err || (abort && res.r_hs > 0)) done = 1;
      if (tail == 4) begin fin = 1; break; end
    end
    res.tmo = !fin;
    res.wdata = o_wdata;
    res.wstrb = o_wstrb;
    res.rready_end = o_rready;
    idle_inputs();
    i_wb_cyc = 0; i_wb_stb = 0;
  endtask

  initial begin
    bit found;
    i_rst = 1; i_wb_adr = 0; i_wb_dat = 0; i_wb_sel = 0; i_wb_we = 0;
    i_wb_cyc = 0; i_wb_stb = 0;
    idle_inputs();

    vt[0] = mk(1, 10'h041, 32'hCAFEBABE, 4'hF, RESP_OKAY, 64'h0,
               12'h100, 64'hCAFEBABE_CAFEBABE, 8'hF0, 32'h0, 1, 0);
    vt[1] = mk(1, 10'h080, 32'h9ABCDEF0, 4'h3, RESP_OKAY, 64'h0,
               12'h200, 64'h9ABCDEF0_9ABCDEF0, 8'h03, 32'h0, 1, 0);
    vt[2] = mk(1, 10'h081, 32'h12345678, 4'h0, RESP_OKAY, 64'h0,
               12'h200, 64'h12345678_12345678, 8'h00, 32'h0, 1, 0);
    vt[3] = mk(0, 10'h042, 32'h0, 4'h0, RESP_OKAY, 64'h11223344_55667788,
               12'h108, 64'h12345678_12345678, 8'h00, 32'h55667788, 1, 0);
    vt[4] = mk(0, 10'h043, 32'h0, 4'h0, RESP_OKAY, 64'h11223344_55667788,
               12'h108, 64'h12345678_12345678, 8'h00, 32'h11223344, 1, 0);
    vt[5] = mk(1, 10'h3FF, 32'hDEADBEEF, 4'h5, RESP_SLVERR, 64'h0,
               12'hFF8, 64'hDEADBEEF_DEADBEEF, 8'h50, 32'h0, 0, 1);
    vt[6] = mk(0, 10'h010, 32'h0, 4'h0, RESP_DECERR, 64'hFFFF0000_FFFF0000,
               12'h040, 64'hDEADBEEF_DEADBEEF, 8'h50, 32'h0, 0, 1);
    vt[7] = mk(0, 10'h011, 32'h0, 4'h0, 2'b01, 64'hA5A50001_0F0F2002,
               12'h040, 64'hDEADBEEF_DEADBEEF, 8'h50, 32'hA5A50001, 1, 0);
    vt[8] = mk(1, 10'h022, 32'h0BADF00D, 4'hC, 2'b01, 64'h0,
               12'h088, 64'h0BADF00D_0BADF00D, 8'h0C, 32'h0, 1, 0);

    repeat (3) @(negedge i_clk);
    chk("reset_ctl", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_wb_ack, o_wb_err}, 0);
    chk("reset_rdt", o_wb_rdt, 0);
    i_rst = 0;

    // Table: all readies immediate, so ack lands 3 cycles after accept.
    for (int i = 0; i < 9; i++) begin
      xfer(vt[i], 1, 1, 0, r);
      chk($sformatf("v%0d_tmo", i), r.tmo, 0);
      chk($sformatf("v%0d_addr", i), r.addr, vt[i].e_addr);
      chk($sformatf("v%0d_wdata", i), r.wdata, vt[i].e_wdata);
      chk($sformatf("v%0d_wstrb", i), r.wstrb, vt[i].e_wstrb);
      if (vt[i].we) begin
        chk($sformatf("v%0d_aw_hs", i), r.aw_hs, 1);
        chk($sformatf("v%0d_w_hs", i), r.w_hs, 1);
        chk($sformatf("v%0d_ar_hs", i), r.ar_hs, 0);
      end else begin
        chk($sformatf("v%0d_ar_hs", i), r.ar_hs, 1);
        chk($sformatf("v%0d_r_hs", i), r.r_hs, 1);
        chk($sformatf("v%0d_aw_hs", i), r.aw_hs, 0);
        if (vt[i].e_ack) chk($sformatf("v%0d_rdt", i), r.rdt, vt[i].e_rdt);
      end
      chk($sformatf("v%0d_n_ack", i), r.n_ack, vt[i].e_ack);
      chk($sformatf("v%0d_n_err", i), r.n_err, vt[i].e_err);
      chk($sformatf("v%0d_lat", i), r.ack_t, 3);
    end

    // awready held off for 4 cycles of awvalid, wready immediate.
    xfer(vt[0], 4, 1, 0, r);
    chk("awdly_tmo", r.tmo, 0);
    chk("awdly_awv_cycles", r.awv, 4);
    chk("awdly_wv_cycles", r.wv, 1);
    chk("awdly_addr_stable", r.stable, 1);
    chk("awdly_addr", r.addr, 12'h100);
    chk("awdly_aw_hs", r.aw_hs, 1);
    chk("awdly_n_ack", r.n_ack, 1);
    chk("awdly_lat", r.ack_t, 6);

    // Reset while waiting in WRESP.
    @(negedge i_clk);
    i_wb_adr = 10'h041; i_wb_dat = 32'h55AA55AA; i_wb_sel = 4'hF; i_wb_we = 1;
    i_wb_cyc = 1; i_wb_stb = 1;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      i_awready = o_awvalid; i_wready = o_wvalid;
      if (o_bready) begin found = 1; break; end
    end
    chk("rst_reached_wresp", found, 1);
    idle_inputs();
    i_rst = 1;
    @(negedge i_clk);
    chk("rst_mid_ctl", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_wb_ack, o_wb_err}, 0);
    chk("rst_mid_rdt", o_wb_rdt, 0);
    i_rst = 0; i_wb_cyc = 0; i_wb_stb = 0;
    @(negedge i_clk);
    chk("rst_post_ctl", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_wb_ack, o_wb_err}, 0);
    xfer(vt[3], 1, 1, 0, r);
    chk("rst_recover_rdt", r.rdt, 32'h55667788);
    chk("rst_recover_lat", r.ack_t, 3);

    // cyc dropped while in RDATA: read completes on AXI, no ack/err.
    xfer(vt[4], 1, 2, 1, r);
    chk("abort_tmo", r.tmo, 0);
    chk("abort_ar_hs", r.ar_hs, 1);
    chk("abort_r_hs", r.r_hs, 1);
    chk("abort_ackerr", {r.n_ack[0], r.n_err[0], r.n_ack > 1, r.n_err > 1}, 0);
    chk("abort_rready_end", r.rready_end, 0);
    xfer(vt[4], 1, 1, 0, r);
    chk("abort_recover_rdt", r.rdt, 32'h11223344);
    chk("abort_recover_n_ack", r.n_ack, 1);
    chk("abort_recover_lat", r.ack_t, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb2axi.md
Name: wb2axi

Overview:
Wishbone classic 32-bit slave bridged to a 64-bit AXI4-Lite master. It is the mirror of the AXI-to-Wishbone path, letting a Wishbone CPU or initiator reach AXI-Lite peripherals and memory. Each Wishbone cycle becomes exactly one AXI-Lite transaction. The 32-bit lane is steered onto the 64-bit bus by address bit 2.

Parameters:
- AW, 12, AXI byte-address width; the Wishbone address is [AW-1:2].

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_wb_adr  in  AW-2  word address [AW-1:2]
- i_wb_dat  in  32  write data
- i_wb_sel  in  4  byte selects
- i_wb_we  in  1  write enable
- i_wb_cyc  in  1  cycle
- i_wb_stb  in  1  strobe
- o_wb_rdt  out  32  read data
- o_wb_ack  out  1  ack pulse
- o_wb_err  out  1  error pulse
- o_awaddr  out  AW  write address
- o_awvalid  out  1  write address valid
- i_awready  in  1  write address ready
- o_wdata  out  64  write data
- o_wstrb  out  8  write strobes
- o_wvalid  out  1  write data valid
- i_wready  in  1  write data ready
- i_bresp  in  2  write response code
- i_bvalid  in  1  write response valid
- o_bready  out  1  write response ready
- o_araddr  out  AW  read address
- o_arvalid  out  1  read address valid
- i_arready  in  1  read address ready
- i_rdata  in  64  read data
- i_rresp  in  2  read response code
- i_rvalid  in  1  read data valid
- o_rready  out  1  read data ready

Behaviour:
- Reset (i_rst=1 at clock edge): all valid, ready, ack and err outputs go to 0; state goes to IDLE; o_wb_rdt goes to 0.
  - Reset mid-transaction aborts immediately, and any outstanding AXI transaction is dropped.
  - Address and data registers are don't-care after reset.
- States: IDLE, WADDR_DATA, WRESP, RADDR, RDATA.
- IDLE: a request is accepted when i_wb_cyc & i_wb_stb & !o_wb_ack.
  - The !o_wb_ack term blocks re-acceptance of the same strobe in the ack cycle.
- Accept, write: the following are registered on the accept edge; valids are high on cycle +1.
  - o_awaddr = {i_wb_adr[AW-1:3], 3'b000}
  - o_wdata = {i_wb_dat, i_wb_dat}
  - o_wstrb = i_wb_adr[2] ? {i_wb_sel, 4'h0} : {4'h0, i_wb_sel}
  - o_awvalid = 1, o_wvalid = 1; go to WADDR_DATA.
- WADDR_DATA: the AW and W handshakes complete independently, in any order or the same cycle.
  - o_awvalid drops the cycle after awvalid & awready; o_wvalid drops the cycle after wvalid & wready.
  - Once both handshakes are done, go to WRESP with o_bready = 1.
  - Valids never drop before their handshake, and o_awaddr/o_wdata/o_wstrb are stable while valid.
- WRESP: on i_bvalid, o_bready drops and state returns to IDLE.
  - o_wb_ack = 1 if i_bresp[1] = 0; otherwise o_wb_err = 1. Exactly one cycle.
- Accept, read: o_araddr = {i_wb_adr[AW-1:3], 3'b000}, o_arvalid = 1; go to RADDR.
  - The lane select (i_wb_adr[2]) is latched internally.
- RADDR: on i_arready, o_arvalid drops, o_rready = 1, go to RDATA.
- RDATA: on i_rvalid:
  - o_wb_rdt = lane ? i_rdata[63:32] : i_rdata[31:0].
  - Ack/err is decided by i_rresp[1], as for writes.
  - o_rready drops; return to IDLE.
- Latency with ready/valid responses in the same cycle:
  - Write: accept edge, AW/W at +1, B at +2, ack at +3.
  - Read: accept edge, AR at +1, R at +2, ack at +3.
- i_wb_sel = 0 on a write: the transaction is still issued with wstrb = 0 and acked normally.
- i_wb_cyc dropped mid-transaction (abort): the AXI transaction still completes, ack/err is suppressed, and the bridge returns to IDLE.
- At most one transaction is outstanding; no write/read arbitration is needed.
- EXOKAY (2'b01) is treated as OKAY.
- Reads leave o_wstrb and o_wdata unchanged.

Decomposition:
- Shared package wb2axi_pkg:
  - state enum
  - response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11
  - helper function for lane-steered strobe generation
- No sub-module needed; lane steering stays inline.

Test Plan:
- Write, adr = 0x104 (adr[2] = 1), dat = 0xCAFEBABE, sel = 0xF, all readies high:
  - awaddr = 0x100, wstrb = 0xF0, wdata = 0xCAFEBABE_CAFEBABE, bresp = 0.
  - Single o_wb_ack exactly 3 cycles after accept.
- Write with awready delayed 4 cycles and wready immediate:
  - o_wvalid drops after 1 cycle; o_awvalid held 4 cycles with stable address; ack after B.
- Read, adr = 0x108 (adr[2] = 0), rdata = 0x11223344_55667788:
  - araddr = 0x108, o_wb_rdt = 0x55667788.
  - Same read at adr = 0x10C returns 0x11223344.
- bresp = SLVERR, then rresp = DECERR:
  - o_wb_err pulses once each; o_wb_ack stays 0.
- Back-to-back strobes with stb held through the ack cycle:
  - Exactly one AXI transaction per Wishbone request; no duplicate issued in the ack cycle.
- i_rst asserted in WRESP, and separately i_wb_cyc dropped in RDATA:
  - Reset case: all valids, ready, ack and err are 0 the next cycle.
  - Abort case: completes the AXI read with no ack and returns to IDLE.
